// File: rtl/ysyx_22040365_opfetch_pkg.sv
// ysyx_22040365_opfetch_pkg: shared widths, register-zero index and FSM encoding for the operand-fetch block.
package ysyx_22040365_opfetch_pkg;
    localparam int XLEN  = 64;
    localparam int AW    = 5;
    localparam int TAG_W = 32;
    localparam logic [AW-1:0] ZERO_REG = '0;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        HOLD = 2'd3
    } state_e;
endpackage

// File: rtl/ysyx_22040365_opf_bypass.sv
// ysyx_22040365_opf_bypass: selects the capture value from the register-file read or a same-edge write.
// Forwarding is enabled by YSYX_22040365_OPF_BYPASS_EN; otherwise the read data passes straight through.
module ysyx_22040365_opf_bypass
    import ysyx_22040365_opfetch_pkg::*;
(
    input  logic [XLEN-1:0] rf_rdata,
    input  logic            wb_wen,
    input  logic [AW-1:0]   wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] cap
);
`ifdef YSYX_22040365_OPF_BYPASS_EN
    assign cap = (wb_wen && wb_waddr == raddr && raddr != ZERO_REG) ? wb_wdata : rf_rdata;
`else
    logic unused_snoop;
    assign unused_snoop = ^{wb_wen, wb_waddr, wb_wdata, raddr};
    assign cap = rf_rdata;
`endif
endmodule

// File: rtl/ysyx_22040365_opfetch.sv
// ysyx_22040365_opfetch: serialises rs1/rs2 reads over one register-file port and hands operands to execute.
// Same-edge write forwarding is selected by YSYX_22040365_OPF_BYPASS_EN (see ysyx_22040365_opf_bypass).
module ysyx_22040365_opfetch
    import ysyx_22040365_opfetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_rs1,
    input  logic [AW-1:0]    in_rs2,
    input  logic             in_rs1_use,
    input  logic             in_rs2_use,
    input  logic [TAG_W-1:0] in_tag,
    output logic             rf_ren,
    output logic [AW-1:0]    rf_raddr,
    input  logic [XLEN-1:0]  rf_rdata,
    input  logic             wb_wen,
    input  logic [AW-1:0]    wb_waddr,
    input  logic [XLEN-1:0]  wb_wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_op1,
    output logic [XLEN-1:0]  out_op2,
    output logic [TAG_W-1:0] out_tag
);
    state_e state_q, state_d;
    logic [AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rf_raddr_q, rf_raddr_d;
    logic use2_q, use2_d, rf_ren_q, rf_ren_d, out_valid_q, out_valid_d;
    logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, cap;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic accept, use1;

    ysyx_22040365_opf_bypass u_bypass (
        .rf_rdata (rf_rdata),
        .wb_wen   (wb_wen),
        .wb_waddr (wb_waddr),
        .wb_wdata (wb_wdata),
        .raddr    (rf_raddr_q),
        .cap      (cap)
    );

    assign in_ready = state_q == IDLE || (state_q == HOLD && out_ready);
    assign accept   = in_valid && in_ready;
    assign use1     = in_rs1_use && in_rs1 != ZERO_REG;

    // Operands are cleared on accept so unused and x0 sources present as zero.
    always_comb begin
        state_d = state_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        use2_d  = use2_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        tag_d   = tag_q;
        if (accept) begin
            rs1_d   = in_rs1;
            rs2_d   = in_rs2;
            use2_d  = in_rs2_use && in_rs2 != ZERO_REG;
            tag_d   = in_tag;
            op1_d   = '0;
            op2_d   = '0;
            state_d = use1 ? RD1 : use2_d ? RD2 : HOLD;
        end else if (state_q == RD1) begin
            op1_d   = cap;
            state_d = use2_q ? RD2 : HOLD;
        end else if (state_q == RD2) begin
            op2_d   = cap;
            state_d = HOLD;
        end else if (state_q == HOLD && out_ready) begin
            state_d = IDLE;
        end
        rf_ren_d    = state_d == RD1 || state_d == RD2;
        rf_raddr_d  = state_d == RD1 ? rs1_d : state_d == RD2 ? rs2_d : ZERO_REG;
        out_valid_d = state_d == HOLD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            use2_q      <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            tag_q       <= '0;
            rf_ren_q    <= 1'b0;
            rf_raddr_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            use2_q      <= use2_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            tag_q       <= tag_d;
            rf_ren_q    <= rf_ren_d;
            rf_raddr_q  <= rf_raddr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign rf_ren    = rf_ren_q;
    assign rf_raddr  = rf_raddr_q;
    assign out_valid = out_valid_q;
    assign out_op1   = op1_q;
    assign out_op2   = op2_q;
    assign out_tag   = tag_q;
endmodule

// File: tb/tb_ysyx_22040365_opfetch.sv
// tb_ysyx_22040365_opfetch: directed plus random transactions against a register-file model and
// a per-transaction expectation of read timing, operand values and handshake behaviour.
module tb_ysyx_22040365_opfetch;
`ifdef YSYX_22040365_OPF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid, in_ready, in_rs1_use, in_rs2_use;
    logic [4:0]  in_rs1, in_rs2, rf_raddr, wb_waddr;
    logic [31:0] in_tag, out_tag;
    logic        rf_ren, wb_wen, out_valid, out_ready;
    logic [63:0] rf_rdata, wb_wdata, out_op1, out_op2;
    logic [63:0] rf [32];
    int vectors = 0, errs = 0;

    ysyx_22040365_opfetch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use),
        .in_tag(in_tag), .rf_ren(rf_ren), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;
    assign rf_rdata = rf[rf_raddr];
    always @(posedge clk) if (wb_wen) rf[wb_waddr] <= wb_wdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input bit rnd, input bit hit, input logic [4:0] idx);
        wb_wen   = hit ? 1'b1 : rnd ? 1'($urandom) : 1'b0;
        wb_waddr = hit ? idx : 5'($urandom);
        wb_wdata = hit ? 64'hDEAD : {$urandom, $urandom};
    endtask

    // Value a read of idx must capture this cycle, given the register contents before the edge.
    function automatic logic [63:0] rd_exp(input logic [4:0] idx);
        return (BYP && wb_wen && wb_waddr == idx && idx != 0) ? wb_wdata : rf[idx];
    endfunction

    task automatic txn(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2,
                       input logic [31:0] tag, input int stall, input bit rnd, input bit hit1);
        logic [63:0] e1, e2;
        bit use1, use2;
        e1 = '0;
        e2 = '0;
        use1 = u1 && rs1 != 0;
        use2 = u2 && rs2 != 0;
        in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rs1_use = u1; in_rs2_use = u2; in_tag = tag;
        out_ready = 1'b1;
        set_wb(rnd, 1'b0, 5'd0);
        #1;
        chk("accept_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        if (use1) begin
            set_wb(rnd, hit1, rs1);
            chk("rd1_ren", rf_ren, 1'b1);
            chk("rd1_addr", rf_raddr, rs1);
            chk("rd1_valid", out_valid, 1'b0);
            chk("rd1_ready", in_ready, 1'b0);
            e1 = rd_exp(rs1);
            step();
        end
        if (use2) begin
            set_wb(rnd, 1'b0, 5'd0);
            chk("rd2_ren", rf_ren, 1'b1);
            chk("rd2_addr", rf_raddr, rs2);
            chk("rd2_valid", out_valid, 1'b0);
            chk("rd2_ready", in_ready, 1'b0);
            e2 = rd_exp(rs2);
            step();
        end
        for (int i = 0; i <= stall; i++) begin
            out_ready = (i == stall);
            in_valid  = (i == stall) ? 1'b0 : 1'($urandom);
            set_wb(rnd, 1'b0, 5'd0);
            #1;
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_op1", out_op1, e1);
            chk("hold_op2", out_op2, e2);
            chk("hold_tag", out_tag, tag);
            chk("hold_ren", rf_ren, 1'b0);
            chk("hold_ready", in_ready, out_ready);
            if (i < stall) step();
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_wb(1'b0, 1'b0, 5'd0);
        step();
        chk("idle_valid", out_valid, 1'b0);
        chk("idle_ready", in_ready, 1'b1);
        chk("idle_ren", rf_ren, 1'b0);
    endtask

    initial begin
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rs1_use = 1'b0; in_rs2_use = 1'b0;
        in_tag = '0; out_ready = 1'b0; wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            wb_wen = 1'b1;
            wb_waddr = 5'(i);
            wb_wdata = i == 3 ? 64'h11 : i == 7 ? 64'h22 : i == 4 ? 64'h44 : {$urandom | 1, $urandom};
            step();
        end
        wb_wen = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_op1", out_op1, 64'd0);
        chk("rst_op2", out_op2, 64'd0);
        chk("rst_tag", out_tag, 32'd0);
        chk("rst_ren", rf_ren, 1'b0);
        chk("rst_raddr", rf_raddr, 5'd0);
        chk("rst_ready", in_ready, 1'b1);
        rst = 1'b0;
        step();
        txn(5'd3, 5'd7, 1'b1, 1'b1, 32'hABCD, 0, 1'b0, 1'b0);
        idle();
        txn(5'd0, 5'd5, 1'b1, 1'b0, 32'h1234, 0, 1'b0, 1'b0);
        idle();
        txn(5'd4, 5'd0, 1'b1, 1'b0, 32'h4444, 0, 1'b0, 1'b1);
        chk("same_edge_write", out_op1, BYP ? 64'hDEAD : 64'h44);
        idle();
        txn(5'd3, 5'd7, 1'b1, 1'b1, 32'h5555, 5, 1'b0, 1'b0);
        txn(5'd7, 5'd3, 1'b1, 1'b1, 32'h6666, 0, 1'b0, 1'b0);
        idle();
        in_valid = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd7; in_rs1_use = 1'b1; in_rs2_use = 1'b1;
        in_tag = 32'h7777;
        step();
        in_valid = 1'b0;
        step();
        chk("pre_rst_rd2", rf_raddr, 5'd7);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_ren", rf_ren, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_raddr", rf_raddr, 5'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dropped_valid", out_valid, 1'b0);
            chk("dropped_ren", rf_ren, 1'b0);
        end
        repeat (150) begin
            txn(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), $urandom,
                int'($urandom_range(0, 2)), 1'b1, 1'b0);
            if ($urandom_range(0, 1) == 0) idle();
        end
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
